dmem_arbiter: RTL
=================

Name: dmem_arbiter

Overview:
- Arbiter for the single-ported 4096x16 data RAM.
- Shares the RAM between the CPU memory stage (port A) and a DMA/program-loader requester (port B).
- One access per cycle. Round-robin arbitration, with optional lock bursts and a starvation bound.
- Sits between the mem stage, the loader and the ram instance. It drives the RAM's raddr/waddr/wen/win and consumes its combinational rout.

Parameters:
- ADDR_W, 12, RAM word-address width.
- DATA_W, 16, data width.
- MAX_BURST, 8, maximum consecutive locked grants while the other port is waiting (legal range 1..255).

Ports:
- clock  in  1  system clock; all state updates on posedge.
- reset  in  1  synchronous, active-low reset (0 = reset); sampled on posedge clock.
- a_req  in  1  port A access request.
- a_we  in  1  port A write enable (1 = write, 0 = read).
- a_lock  in  1  port A asks to keep ownership after this beat.
- a_addr  in  ADDR_W  port A word address.
- a_wdata  in  DATA_W  port A write data.
- a_gnt  out  1  port A access performed this cycle.
- a_rvalid  out  1  port A read data valid (one cycle after a granted read).
- a_rdata  out  DATA_W  port A read data.
- b_req, b_we, b_lock, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata: same as port A, for port B.
- ram_addr  out  ADDR_W  drives both raddr and waddr of the RAM.
- ram_wen  out  1  RAM write enable.
- ram_win  out  DATA_W  RAM write data.
- ram_rout  in  DATA_W  RAM combinational read data.

Behaviour:
- **Reset (reset==0 at posedge):**
  - state=IDLE, last=B (so A wins the first tie), burst_cnt=0.
  - a_rvalid=b_rvalid=0, a_rdata=b_rdata=0.
  - While reset is low: a_gnt=b_gnt=0 and ram_wen=0.
  - Reset mid-burst drops ownership immediately; no partial access is committed.
- **Grant timing:**
  - Grants are combinational in the request cycle.
  - The granted port's addr/we/wdata are muxed onto ram_*.
  - A granted write commits at the same posedge.
  - When nothing is granted: ram_addr=0, ram_wen=0, ram_win=0.
- **Read return:**
  - A granted read registers ram_rout into x_rdata at that posedge.
  - x_rvalid=1 for exactly the following cycle.
  - x_rdata holds its value until the next granted read of that port.
  - Writes never raise rvalid.
- **Requester rule:** each requester holds req/addr/we/wdata stable until it sees gnt high. gnt is a one-cycle pulse per beat; back-to-back beats are allowed.
- **State IDLE:**
  - Only one req: grant it.
  - Both req: grant the port other than last.
  - The granted port becomes last.
  - If the granted port's lock=1: go to OWN_A/OWN_B with burst_cnt=1.
- **State OWN_x:**
  - x_req=1: grant x and increment burst_cnt (saturating at 255).
  - x_req=0 or x_lock=0 on a granted beat: return to IDLE after that beat.
  - x_req=0: no grant to x. If the other port requests, it is granted this cycle under the IDLE rules.
- **Starvation bound:** in OWN_x, if burst_cnt==MAX_BURST and the other port requests, the other port is granted this cycle (x not granted) and arbitration proceeds as IDLE from that grant, including entry into its own OWN state if its lock=1.
- **Counter:** burst_cnt resets to 0 on every return to IDLE.
- **Addresses:** naturally ADDR_W bits; no range checks, wrap is implicit.
- **Simultaneous access:** only one access per cycle. The losing port simply sees gnt=0; its request is retried, never queued.

Optional Feature:
- Macro DMEM_ARB_FIXED_PRIO_EN.
- **Defined:**
  - Port A (CPU) always wins ties in IDLE; last is ignored.
  - OWN_B is pre-empted whenever a_req=1, regardless of burst_cnt.
  - OWN_A ignores MAX_BURST.
- **Undefined:** round-robin with MAX_BURST bound as described above.

Test Plan:
- **Reset:** hold reset=0 for 3 cycles with a_req=b_req=1, a_we=1 -> a_gnt=b_gnt=0, ram_wen=0, rvalid=0, rdata=0.
- **Write then read:**
  - A writes 0x1234 to 0x005 -> a_gnt=1, ram_wen=1.
  - B then reads 0x005 -> b_gnt=1; next cycle b_rvalid=1, b_rdata=0x1234.
- **Tie round-robin:** a_req=b_req=1 (reads, no lock) for 4 cycles after reset -> grant sequence A,B,A,B; each rvalid one cycle after its grant.
- **Lock burst with starvation bound:**
  - B locks, reading 0x100..0x10F; A requests from cycle 2.
  - -> B granted 8 beats (MAX_BURST=8), then A granted once, then B resumes.
  - With DMEM_ARB_FIXED_PRIO_EN: A is granted the first cycle it requests.
- **Wrap:** A writes 0xBEEF at 0xFFF, then reads 0xFFF -> a_rdata=0xBEEF; address 0x000 unchanged.
- **Reset mid-burst:**
  - A locked for 3 beats; reset=0 for 1 cycle -> no gnt and no wen that cycle, state IDLE.
  - After release with both requesting -> A granted first (last=B).

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-ported RAM between the CPU (port A) and DMA (port B).
// Round-robin with lock bursts and a starvation bound; define DMEM_ARB_FIXED_PRIO_EN for A-priority.
module dmem_arbiter #(
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = 16,
  parameter int MAX_BURST = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              a_req,
  input  logic              a_we,
  input  logic              a_lock,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_gnt,
  output logic              a_rvalid,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic              b_lock,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_gnt,
  output logic              b_rvalid,
  output logic [DATA_W-1:0] b_rdata,
  output logic [ADDR_W-1:0] ram_addr,
  output logic              ram_wen,
  output logic [DATA_W-1:0] ram_win,
  input  logic [DATA_W-1:0] ram_rout
);

  typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

  localparam logic LAST_A = 1'b0;
  localparam logic LAST_B = 1'b1;

  state_t     state, state_nxt;
  logic       last, last_nxt;
  logic [7:0] burst_cnt, burst_cnt_nxt;
  logic [7:0] burst_inc;
  logic       keep_a, keep_b, open_arb, tie_a, pick_a, pick_b;

`ifdef DMEM_ARB_FIXED_PRIO_EN
  assign keep_a = (state == OWN_A) && a_req;
  assign keep_b = (state == OWN_B) && b_req && !a_req;
  assign tie_a  = 1'b1;
`else
  localparam logic [7:0] MAX_CNT = 8'(MAX_BURST);
  assign keep_a = (state == OWN_A) && a_req && !(b_req && burst_cnt == MAX_CNT);
  assign keep_b = (state == OWN_B) && b_req && !(a_req && burst_cnt == MAX_CNT);
  assign tie_a  = (last == LAST_B);
`endif

  // A displaced owner is always 'last', so the tie rule hands the beat to the waiting port.
  assign open_arb  = !keep_a && !keep_b;
  assign pick_a    = a_req && (!b_req || tie_a);
  assign pick_b    = b_req && !pick_a;
  assign a_gnt     = reset && (keep_a || (open_arb && pick_a));
  assign b_gnt     = reset && (keep_b || (open_arb && pick_b));
  assign burst_inc = (burst_cnt == 8'hFF) ? burst_cnt : burst_cnt + 8'd1;

  always_comb begin
    state_nxt     = IDLE;
    burst_cnt_nxt = 8'd0;
    last_nxt      = last;
    if (a_gnt) begin
      last_nxt = LAST_A;
      if (a_lock) begin
        state_nxt     = OWN_A;
        burst_cnt_nxt = keep_a ? burst_inc : 8'd1;
      end
    end else if (b_gnt) begin
      last_nxt = LAST_B;
      if (b_lock) begin
        state_nxt     = OWN_B;
        burst_cnt_nxt = keep_b ? burst_inc : 8'd1;
      end
    end
  end

  always_comb begin
    ram_addr = '0;
    ram_wen  = 1'b0;
    ram_win  = '0;
    if (a_gnt) begin
      ram_addr = a_addr;
      ram_wen  = a_we;
      ram_win  = a_wdata;
    end else if (b_gnt) begin
      ram_addr = b_addr;
      ram_wen  = b_we;
      ram_win  = b_wdata;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= LAST_B;
      burst_cnt <= 8'd0;
      a_rvalid  <= 1'b0;
      b_rvalid  <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      state     <= state_nxt;
      last      <= last_nxt;
      burst_cnt <= burst_cnt_nxt;
      a_rvalid  <= a_gnt && !a_we;
      b_rvalid  <= b_gnt && !b_we;
      if (a_gnt && !a_we) a_rdata <= ram_rout;
      if (b_gnt && !b_we) b_rdata <= ram_rout;
    end
  end

endmodule
